// File: rtl/transducer_pkg.sv
// Shared types and default widths for the multi-channel transducer pulser.
// Holds the global FSM state enum and the per-channel phase enum.
package transducer_pkg;

   localparam int DEF_N_CH       = 8;
   localparam int DEF_PD_W       = 16;
   localparam int DEF_CT_W       = 9;
   localparam int DEF_RT_W       = 9;
   localparam int DEF_BC_W       = 4;
   localparam int DEF_WDOG_LIMIT = 512;

   typedef enum logic [2:0] {IDLE, ARMED, FIRING, DONE, FAULT} state_t;

   typedef enum logic [1:0] {DELAY, HIGH, REST, FINISHED} phase_t;

endpackage

// File: rtl/pulser_channel.sv
// One transducer channel: phase delay, charge (high) time, burst with rest gaps,
// output mask and a consecutive-high watchdog.
module pulser_channel
   import transducer_pkg::*;
#(
   parameter int PD_W       = DEF_PD_W,
   parameter int CT_W       = DEF_CT_W,
   parameter int RT_W       = DEF_RT_W,
   parameter int BC_W       = DEF_BC_W,
   parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic            mask,
   input  logic [PD_W-1:0] phaseDelay,
   input  logic [CT_W-1:0] chargeTime,
   input  logic [RT_W-1:0] restTime,
   input  logic [BC_W-1:0] burstCount,
   output logic            txOut,
   output logic            doneNext,
   output logic            wdTrip
);

   localparam int WD_W = $clog2(WDOG_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_LIMIT);

   phase_t          phase, phaseNext;
   logic [PD_W-1:0] delayCnt, delayNext;
   logic [CT_W-1:0] highCnt, highNext;
   logic [RT_W-1:0] restCnt, restNext;
   logic [BC_W-1:0] burstLeft, burstNext;
   logic [WD_W-1:0] wdCnt, wdNext;
   logic            txNext;
   logic            maskReg;

   always_comb begin
      phaseNext = phase;
      delayNext = delayCnt;
      highNext  = highCnt;
      restNext  = restCnt;
      burstNext = burstLeft;
      txNext    = 1'b0;
      if (kill) begin
         phaseNext = FINISHED;
         delayNext = '0;
         highNext  = '0;
         restNext  = '0;
         burstNext = '0;
      end else if (start) begin
         phaseNext = DELAY;
         delayNext = phaseDelay;
         highNext  = '0;
         restNext  = '0;
         burstNext = (burstCount == '0) ? BC_W'(1) : burstCount;
      end else begin
         case (phase)
            DELAY: begin
               if (delayCnt != '0) begin
                  delayNext = delayCnt - 1'b1;
               end else if (chargeTime == '0) begin
                  phaseNext = FINISHED;
               end else begin
                  phaseNext = HIGH;
                  highNext  = chargeTime;
                  txNext    = ~maskReg;
               end
            end
            HIGH: begin
               if (highCnt > CT_W'(1)) begin
                  highNext = highCnt - 1'b1;
                  txNext   = ~maskReg;
               end else begin
                  highNext = '0;
                  if (burstLeft > BC_W'(1)) begin
                     phaseNext = REST;
                     burstNext = burstLeft - 1'b1;
                     restNext  = (restTime == '0) ? RT_W'(1) : restTime;
                  end else begin
                     phaseNext = FINISHED;
                     burstNext = '0;
                  end
               end
            end
            REST: begin
               if (restCnt > RT_W'(1)) begin
                  restNext = restCnt - 1'b1;
               end else begin
                  restNext  = '0;
                  phaseNext = HIGH;
                  highNext  = chargeTime;
                  txNext    = ~maskReg;
               end
            end
            default: ;
         endcase
      end
   end

   // Count includes the cycle being driven, so wdCnt equals k in the k-th high cycle.
   always_comb begin
      wdNext = '0;
      if (txNext) begin
         wdNext = (wdCnt == WD_LIMIT) ? wdCnt : wdCnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase     <= FINISHED;
         delayCnt  <= '0;
         highCnt   <= '0;
         restCnt   <= '0;
         burstLeft <= '0;
         wdCnt     <= '0;
         txOut     <= 1'b0;
         maskReg   <= 1'b0;
      end else begin
         phase     <= phaseNext;
         delayCnt  <= delayNext;
         highCnt   <= highNext;
         restCnt   <= restNext;
         burstLeft <= burstNext;
         wdCnt     <= wdNext;
         txOut     <= txNext;
         if (start) begin
            maskReg <= mask;
         end
      end
   end

   assign doneNext = (phaseNext == FINISHED);
   assign wdTrip   = (wdCnt == WD_LIMIT);

endmodule

// File: rtl/transducer_array_pulser.sv
// Multi-channel transducer pulser: global arm/fire FSM, configuration shadow
// registers, per-channel pulsers and fault/completion aggregation.
module transducer_array_pulser
   import transducer_pkg::*;
#(
   parameter int N_CH       = DEF_N_CH,
   parameter int PD_W       = DEF_PD_W,
   parameter int CT_W       = DEF_CT_W,
   parameter int RT_W       = DEF_RT_W,
   parameter int BC_W       = DEF_BC_W,
   parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 arm,
   input  logic                 fire,
   input  logic                 abort,
   input  logic [N_CH-1:0]      ch_mask,
   input  logic [N_CH*PD_W-1:0] phase_delay,
   input  logic [CT_W-1:0]      charge_time,
   input  logic [RT_W-1:0]      rest_time,
   input  logic [BC_W-1:0]      burst_count,
   output logic [N_CH-1:0]      tx_out,
   output logic                 busy,
   output logic                 fire_complete,
   output logic                 warning,
   output logic [N_CH-1:0]      fault_ch
);

   state_t               state, stateNext;
   logic [N_CH*PD_W-1:0] delayShadow;
   logic [CT_W-1:0]      chargeShadow;
   logic [RT_W-1:0]      restShadow;
   logic [BC_W-1:0]      burstShadow;
   logic [N_CH-1:0]      maskShadow;
   logic [N_CH-1:0]      faultCh;
   logic [N_CH-1:0]      chTx, chDoneNext, chTrip;
   logic                 startFire, capture, killCh;

   // Watchdog fault outranks abort, which outranks arm/fire.
   always_comb begin
      stateNext = state;
      startFire = 1'b0;
      capture   = 1'b0;
      killCh    = 1'b0;
      if ((|chTrip) || state == FAULT) begin
         stateNext = FAULT;
         killCh    = 1'b1;
      end else if (abort && (state == ARMED || state == FIRING)) begin
         stateNext = IDLE;
         killCh    = 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (arm) begin
                  stateNext = ARMED;
                  capture   = 1'b1;
               end
            end
            ARMED: begin
               if (fire) begin
                  stateNext = FIRING;
                  startFire = 1'b1;
               end else if (arm) begin
                  capture = 1'b1;
               end
            end
            FIRING: begin
               if (&chDoneNext) begin
                  stateNext = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         delayShadow  <= '0;
         chargeShadow <= '0;
         restShadow   <= '0;
         burstShadow  <= '0;
         maskShadow   <= '0;
         faultCh      <= '0;
      end else begin
         state   <= stateNext;
         faultCh <= faultCh | chTrip;
         if (capture) begin
            delayShadow  <= phase_delay;
            chargeShadow <= charge_time;
            restShadow   <= rest_time;
            burstShadow  <= burst_count;
            maskShadow   <= ch_mask;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : gChannel
         pulser_channel #(
            .PD_W       (PD_W),
            .CT_W       (CT_W),
            .RT_W       (RT_W),
            .BC_W       (BC_W),
            .WDOG_LIMIT (WDOG_LIMIT)
         ) uChannel (
            .clk        (clk),
            .rst        (rst),
            .start      (startFire),
            .kill       (killCh),
            .mask       (maskShadow[gi]),
            .phaseDelay (delayShadow[gi*PD_W +: PD_W]),
            .chargeTime (chargeShadow),
            .restTime   (restShadow),
            .burstCount (burstShadow),
            .txOut      (chTx[gi]),
            .doneNext   (chDoneNext[gi]),
            .wdTrip     (chTrip[gi])
         );
      end
   endgenerate

   assign tx_out        = chTx;
   assign busy          = (state == ARMED) || (state == FIRING);
   assign fire_complete = (state == IDLE) || (state == DONE);
   assign warning       = (state == FAULT);
   assign fault_ch      = faultCh;

endmodule

// File: tb/tb_transducer_array_pulser.sv
// Directed self-checking bench for transducer_array_pulser (4 channels, 16-cycle watchdog).
module tb_transducer_array_pulser;

   localparam int N_CH       = 4;
   localparam int PD_W       = 16;
   localparam int CT_W       = 6;
   localparam int RT_W       = 9;
   localparam int BC_W       = 4;
   localparam int WDOG_LIMIT = 16;

   logic                 clk = 1'b0;
   logic                 rst, arm, fire, abort;
   logic [N_CH-1:0]      ch_mask;
   logic [N_CH*PD_W-1:0] phase_delay;
   logic [CT_W-1:0]      charge_time;
   logic [RT_W-1:0]      rest_time;
   logic [BC_W-1:0]      burst_count;
   logic [N_CH-1:0]      tx_out, fault_ch;
   logic                 busy, fire_complete, warning;

   int checks = 0;
   int errors = 0;
   int dly[N_CH];

   always #5 clk = ~clk;

   transducer_array_pulser #(
      .N_CH(N_CH), .PD_W(PD_W), .CT_W(CT_W), .RT_W(RT_W), .BC_W(BC_W), .WDOG_LIMIT(WDOG_LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .arm(arm), .fire(fire), .abort(abort), .ch_mask(ch_mask),
      .phase_delay(phase_delay), .charge_time(charge_time), .rest_time(rest_time),
      .burst_count(burst_count), .tx_out(tx_out), .busy(busy), .fire_complete(fire_complete),
      .warning(warning), .fault_ch(fault_ch)
   );

   // Channel with delay p is high in cycles fire+2+p+j*(c+r) .. +c-1 for pulse j.
   function automatic logic expTx(input int p, input int c, input int r, input int b, input int k);
      int rr;
      int s;
      rr = (r == 0) ? 1 : r;
      for (int j = 0; j < b; j++) begin
         s = 2 + p + j * (c + rr);
         if (k >= s && k <= s + c - 1) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic setDelays(input int d0, input int d1, input int d2, input int d3);
      dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
      phase_delay = {PD_W'(d3), PD_W'(d2), PD_W'(d1), PD_W'(d0)};
   endtask

   task automatic armCfg(input logic [N_CH-1:0] m, input int c, input int r, input int b);
      ch_mask     = m;
      charge_time = CT_W'(c);
      rest_time   = RT_W'(r);
      burst_count = BC_W'(b);
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; arm = 1'b0; fire = 1'b0; abort = 1'b0;
      setDelays(0, 0, 0, 0);
      armCfg('0, 0, 0, 0);
      step();
      rst = 1'b1;
      checks++; if (tx_out !== 4'b0000) begin errors++; $display("FAIL reset_tx got=%b exp=0000", tx_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (fire_complete !== 1'b1) begin errors++; $display("FAIL reset_fc got=%b exp=1", fire_complete); end
      checks++; if (warning !== 1'b0) begin errors++; $display("FAIL reset_warning got=%b exp=0", warning); end
      checks++; if (fault_ch !== 4'b0000) begin errors++; $display("FAIL reset_fault_ch got=%b exp=0000", fault_ch); end
      $display("test_reset done");
   endtask

   task automatic test_phase_delay();
      logic [N_CH-1:0] e;
      setDelays(0, 3, 7, 1);
      armCfg(4'b0000, 5, 0, 1);
      checks++; if (busy !== 1'b1 || fire_complete !== 1'b0) begin
         errors++; $display("FAIL armed_flags got busy=%b fc=%b exp busy=1 fc=0", busy, fire_complete);
      end
      fire = 1'b1; step(); fire = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         for (int i = 0; i < N_CH; i++) e[i] = expTx(dly[i], 5, 0, 1, k);
         checks++; if (tx_out !== e) begin errors++; $display("FAIL delay_tx k=%0d got=%b exp=%b", k, tx_out, e); end
         checks++; if (fire_complete !== (k >= 14)) begin
            errors++; $display("FAIL delay_fc k=%0d got=%b exp=%b", k, fire_complete, (k >= 14));
         end
         step();
      end
      $display("test_phase_delay done");
   endtask

   task automatic test_burst();
      logic [N_CH-1:0] e;
      setDelays(0, 0, 0, 0);
      armCfg(4'b0000, 2, 4, 3);
      fire = 1'b1; step(); fire = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         for (int i = 0; i < N_CH; i++) e[i] = expTx(0, 2, 4, 3, k);
         checks++; if (tx_out !== e) begin errors++; $display("FAIL burst_tx k=%0d got=%b exp=%b", k, tx_out, e); end
         checks++; if (busy !== (k < 16)) begin errors++; $display("FAIL burst_busy k=%0d got=%b exp=%b", k, busy, (k < 16)); end
         step();
      end
      $display("test_burst done");
   endtask

   task automatic test_mask();
      logic [N_CH-1:0] e;
      setDelays(0, 3, 7, 1);
      armCfg(4'b0100, 5, 0, 1);
      fire = 1'b1; step(); fire = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         for (int i = 0; i < N_CH; i++) e[i] = expTx(dly[i], 5, 0, 1, k);
         e[2] = 1'b0;
         checks++; if (tx_out !== e) begin errors++; $display("FAIL mask_tx k=%0d got=%b exp=%b", k, tx_out, e); end
         checks++; if (fire_complete !== (k >= 14)) begin
            errors++; $display("FAIL mask_fc k=%0d got=%b exp=%b", k, fire_complete, (k >= 14));
         end
         step();
      end
      $display("test_mask done");
   endtask

   task automatic test_zero_charge();
      setDelays(0, 3, 7, 1);
      armCfg(4'b0000, 0, 0, 1);
      fire = 1'b1; step(); fire = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         checks++; if (tx_out !== 4'b0000) begin errors++; $display("FAIL zc_tx k=%0d got=%b exp=0000", k, tx_out); end
         checks++; if (fire_complete !== (k >= 9)) begin
            errors++; $display("FAIL zc_fc k=%0d got=%b exp=%b", k, fire_complete, (k >= 9));
         end
         step();
      end
      $display("test_zero_charge done");
   endtask

   task automatic test_abort();
      logic [N_CH-1:0] e;
      setDelays(0, 3, 7, 1);
      armCfg(4'b0000, 5, 0, 1);
      fire = 1'b1; step(); fire = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         for (int i = 0; i < N_CH; i++) e[i] = expTx(dly[i], 5, 0, 1, k);
         checks++; if (tx_out !== e) begin errors++; $display("FAIL abort_pre_tx k=%0d got=%b exp=%b", k, tx_out, e); end
         if (k == 4) abort = 1'b1;
         step();
      end
      abort = 1'b0;
      checks++; if (tx_out !== 4'b0000) begin errors++; $display("FAIL abort_tx got=%b exp=0000", tx_out); end
      checks++; if (fire_complete !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_idle got fc=%b busy=%b exp fc=1 busy=0", fire_complete, busy);
      end
      step();
      checks++; if (tx_out !== 4'b0000) begin errors++; $display("FAIL abort_hold_tx got=%b exp=0000", tx_out); end
      $display("test_abort done");
   endtask

   task automatic test_fire_without_arm();
      fire = 1'b1; step(); fire = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         checks++; if (busy !== 1'b0 || tx_out !== 4'b0000) begin
            errors++; $display("FAIL noarm k=%0d got busy=%b tx=%b exp busy=0 tx=0000", k, busy, tx_out);
         end
         step();
      end
      $display("test_fire_without_arm done");
   endtask

   task automatic test_input_change();
      logic [N_CH-1:0] e;
      setDelays(0, 3, 7, 1);
      armCfg(4'b0000, 5, 0, 1);
      phase_delay = {4{PD_W'(9)}};
      charge_time = CT_W'(20);
      ch_mask     = 4'b1111;
      burst_count = BC_W'(5);
      step();
      fire = 1'b1; step(); fire = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         for (int i = 0; i < N_CH; i++) e[i] = expTx(dly[i], 5, 0, 1, k);
         checks++; if (tx_out !== e) begin errors++; $display("FAIL shadow_tx k=%0d got=%b exp=%b", k, tx_out, e); end
         checks++; if (fire_complete !== (k >= 14)) begin
            errors++; $display("FAIL shadow_fc k=%0d got=%b exp=%b", k, fire_complete, (k >= 14));
         end
         arm = (k == 3);
         step();
      end
      arm = 1'b0;
      $display("test_input_change done");
   endtask

   task automatic test_watchdog();
      logic [N_CH-1:0] e;
      setDelays(0, 0, 0, 0);
      armCfg(4'b0010, 40, 0, 1);
      fire = 1'b1; step(); fire = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         e = (k >= 2) ? 4'b1101 : 4'b0000;
         checks++; if (tx_out !== e) begin errors++; $display("FAIL wd_tx k=%0d got=%b exp=%b", k, tx_out, e); end
         checks++; if (warning !== 1'b0) begin errors++; $display("FAIL wd_early k=%0d got=%b exp=0", k, warning); end
         step();
      end
      checks++; if (tx_out !== 4'b0000) begin errors++; $display("FAIL wd_kill_tx got=%b exp=0000", tx_out); end
      checks++; if (warning !== 1'b1) begin errors++; $display("FAIL wd_warning got=%b exp=1", warning); end
      checks++; if (fault_ch !== 4'b1101) begin errors++; $display("FAIL wd_fault_ch got=%b exp=1101", fault_ch); end
      checks++; if (fire_complete !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL wd_flags got fc=%b busy=%b exp fc=0 busy=0", fire_complete, busy);
      end
      armCfg(4'b0000, 3, 0, 1);
      fire = 1'b1; step(); fire = 1'b0;
      abort = 1'b1; step(); abort = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         checks++; if (warning !== 1'b1 || tx_out !== 4'b0000 || busy !== 1'b0 || fire_complete !== 1'b0) begin
            errors++; $display("FAIL wd_sticky k=%0d got warn=%b tx=%b busy=%b fc=%b exp 1 0000 0 0",
                               k, warning, tx_out, busy, fire_complete);
         end
         step();
      end
      rst = 1'b0; step(); rst = 1'b1;
      checks++; if (warning !== 1'b0 || fault_ch !== 4'b0000 || fire_complete !== 1'b1) begin
         errors++; $display("FAIL wd_clear got warn=%b fault_ch=%b fc=%b exp 0 0000 1", warning, fault_ch, fire_complete);
      end
      $display("test_watchdog done");
   endtask

   task automatic test_reset_mid_burst();
      setDelays(0, 0, 0, 0);
      armCfg(4'b0000, 2, 4, 3);
      fire = 1'b1; step(); fire = 1'b0;
      for (int k = 1; k < 8; k++) step();
      checks++; if (tx_out !== 4'b1111) begin errors++; $display("FAIL midrst_pre got=%b exp=1111", tx_out); end
      rst = 1'b0; step(); rst = 1'b1;
      checks++; if (tx_out !== 4'b0000 || busy !== 1'b0 || fire_complete !== 1'b1 || warning !== 1'b0) begin
         errors++; $display("FAIL midrst got tx=%b busy=%b fc=%b warn=%b exp 0000 0 1 0", tx_out, busy, fire_complete, warning);
      end
      for (int k = 1; k <= 10; k++) begin
         checks++; if (tx_out !== 4'b0000) begin errors++; $display("FAIL midrst_hold k=%0d got=%b exp=0000", k, tx_out); end
         step();
      end
      $display("test_reset_mid_burst done");
   endtask

   initial begin
      test_reset();
      test_phase_delay();
      test_burst();
      test_mask();
      test_zero_charge();
      test_abort();
      test_fire_without_arm();
      test_input_change();
      test_watchdog();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
